// File: rtl/fb_pkg.sv
// fb_pkg: shared widths, pixel/address types and the address range check
// for the 320x240 RGB444 frame buffer.
package fb_pkg;

  localparam int unsigned FB_DATA_W = 12;
  localparam int unsigned FB_ADDR_W = 17;
  localparam int unsigned FB_DEPTH  = 76800;  // 320 x 240

  typedef logic [FB_ADDR_W-1:0] fb_addr_t;

  // One RGB444 pixel, red in the MSBs
  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb444_t;

  // True when the address names a real pixel; no wrapping of larger addresses
  function automatic logic fb_in_range(input fb_addr_t addr);
    return addr < FB_ADDR_W'(FB_DEPTH);
  endfunction

endpackage

// File: rtl/fb_ram_core.sv
// fb_ram_core: bare pixel array, one write port and an unregistered read index.
// Reading in the same cycle as a write to the same word returns the old word,
// because the caller registers rd_data_c on the same edge the write lands.
module fb_ram_core
  import fb_pkg::*;
(
  input  logic     clk,
  input  logic     we,
  input  fb_addr_t wr_addr,
  input  rgb444_t  wr_data,
  input  fb_addr_t rd_addr,
  output rgb444_t  rd_data_c
);

  // Zero at power-up; reset never clears the contents
  rgb444_t mem [FB_DEPTH] = '{default: '0};

  // Write port; the caller guarantees wr_addr is in range when we is high
  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data_c = mem[rd_addr];

endmodule

// File: rtl/frame_buffer_mem.sv
// frame_buffer_mem: camera-write / VGA-read frame buffer with registered read
// data, read-valid flag, out-of-range protection and sticky oob flags.
// Build option FRAME_BUFFER_OUT_REG_EN adds a second output stage (latency 2).
module frame_buffer_mem
  import fb_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ena,
  input  logic                 wea,
  input  logic [FB_ADDR_W-1:0] addra,
  input  logic [FB_DATA_W-1:0] dina,
  input  logic                 enb,
  input  logic [FB_ADDR_W-1:0] addrb,
  output logic [FB_DATA_W-1:0] doutb,
  output logic                 doutb_valid,
  output logic                 wr_oob,
  output logic                 rd_oob
);

  logic    wr_req_c;
  logic    wr_ok_c;
  logic    rd_ok_c;
  logic    ram_we_c;
  rgb444_t ram_rd_c;
  rgb444_t dout_q;
  logic    valid_q;

  assign wr_req_c = ena & wea;
  assign wr_ok_c  = fb_in_range(fb_addr_t'(addra));
  assign rd_ok_c  = fb_in_range(fb_addr_t'(addrb));
  assign ram_we_c = ~rst & wr_req_c & wr_ok_c;

  fb_ram_core u_ram (
    .clk       (clk),
    .we        (ram_we_c),
    .wr_addr   (fb_addr_t'(addra)),
    .wr_data   (rgb444_t'(dina)),
    .rd_addr   (fb_addr_t'(addrb)),
    .rd_data_c (ram_rd_c)
  );

  // First output stage: capture read data (zero for oob), hold when idle
  always_ff @(posedge clk) begin
    if (rst) begin
      dout_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= enb;
      if (enb) begin
        dout_q <= rd_ok_c ? ram_rd_c : '0;
      end
    end
  end

  // Sticky oob flags; reset wins over a same-cycle set
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_oob <= 1'b0;
      rd_oob <= 1'b0;
    end else begin
      if (wr_req_c && !wr_ok_c) begin
        wr_oob <= 1'b1;
      end
      if (enb && !rd_ok_c) begin
        rd_oob <= 1'b1;
      end
    end
  end

`ifdef FRAME_BUFFER_OUT_REG_EN
  rgb444_t dout_q2;
  logic    valid_q2;

  // Optional second output stage for timing closure toward the pixel pipeline
  always_ff @(posedge clk) begin
    if (rst) begin
      dout_q2  <= '0;
      valid_q2 <= 1'b0;
    end else begin
      dout_q2  <= dout_q;
      valid_q2 <= valid_q;
    end
  end

  assign doutb       = FB_DATA_W'(dout_q2);
  assign doutb_valid = valid_q2;
`else
  assign doutb       = FB_DATA_W'(dout_q);
  assign doutb_valid = valid_q;
`endif

endmodule

// File: tb/tb_frame_buffer_mem.sv
// tb_frame_buffer_mem: directed scenarios, random traffic and a full read
// sweep, all checked against an array-based reference model of the buffer.
module tb_frame_buffer_mem;
  import fb_pkg::*;

  localparam int unsigned DEPTH = FB_DEPTH;
`ifdef FRAME_BUFFER_OUT_REG_EN
  localparam int unsigned LAT = 2;
`else
  localparam int unsigned LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        ena;
  logic        wea;
  logic [16:0] addra;
  logic [11:0] dina;
  logic        enb;
  logic [16:0] addrb;
  logic [11:0] doutb;
  logic        doutb_valid;
  logic        wr_oob;
  logic        rd_oob;

  frame_buffer_mem dut (
    .clk         (clk),
    .rst         (rst),
    .ena         (ena),
    .wea         (wea),
    .addra       (addra),
    .dina        (dina),
    .enb         (enb),
    .addrb       (addrb),
    .doutb       (doutb),
    .doutb_valid (doutb_valid),
    .wr_oob      (wr_oob),
    .rd_oob      (rd_oob)
  );

  always #5 clk = ~clk;

  // Reference model: pixel array, delay line of read results, sticky flags
  logic [11:0] ref_mem [DEPTH];
  logic [11:0] exp_data [LAT];
  logic        exp_vld  [LAT];
  logic        exp_wr_oob;
  logic        exp_rd_oob;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Apply the rules of one clock edge to the model (read sees pre-write contents)
  task automatic model_edge();
    logic [11:0] rd_val;
    for (int i = LAT - 1; i > 0; i--) begin
      exp_data[i] = exp_data[i-1];
      exp_vld[i]  = exp_vld[i-1];
    end
    if (rst) begin
      for (int i = 0; i < LAT; i++) begin
        exp_data[i] = '0;
        exp_vld[i]  = 1'b0;
      end
      exp_wr_oob = 1'b0;
      exp_rd_oob = 1'b0;
    end else begin
      if (enb) begin
        if (int'(addrb) < DEPTH) rd_val = ref_mem[addrb];
        else begin
          rd_val = '0;
          exp_rd_oob = 1'b1;
        end
        exp_data[0] = rd_val;
        exp_vld[0]  = 1'b1;
      end else begin
        exp_vld[0] = 1'b0;
      end
      if (ena && wea) begin
        if (int'(addra) < DEPTH) ref_mem[addra] = dina;
        else exp_wr_oob = 1'b1;
      end
    end
  endtask

  // Drive one cycle of inputs, step the model at the edge, compare after it
  task automatic cycle(input logic r, input logic ea, input logic wa, input int aa,
                       input logic [11:0] da, input logic eb, input int ab);
    @(negedge clk);
    rst = r; ena = ea; wea = wa; addra = 17'(aa); dina = da; enb = eb; addrb = 17'(ab);
    @(posedge clk);
    model_edge();
    #1;
    check("doutb", 32'(doutb), 32'(exp_data[LAT-1]));
    check("doutb_valid", 32'(doutb_valid), 32'(exp_vld[LAT-1]));
    check("wr_oob", 32'(wr_oob), 32'(exp_wr_oob));
    check("rd_oob", 32'(rd_oob), 32'(exp_rd_oob));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 0, 12'h000, 1'b0, 0);
  endtask

  task automatic wr(input int a, input logic [11:0] d);
    cycle(1'b0, 1'b1, 1'b1, a, d, 1'b0, 0);
  endtask

  task automatic rd(input int a);
    cycle(1'b0, 1'b0, 1'b0, 0, 12'h000, 1'b1, a);
  endtask

  // Issue a read, let it reach the output, and check against a fixed value
  task automatic rd_expect(input string tag, input int a, input logic [11:0] d);
    rd(a);
    if (LAT > 1) idle(int'(LAT) - 1);
    check(tag, 32'(doutb), 32'(d));
  endtask

  initial begin
    foreach (ref_mem[i]) ref_mem[i] = '0;
    for (int i = 0; i < LAT; i++) begin
      exp_data[i] = '0;
      exp_vld[i]  = 1'b0;
    end
    exp_wr_oob = 1'b0;
    exp_rd_oob = 1'b0;
    rst = 1'b1; ena = 1'b0; wea = 1'b0; addra = '0; dina = '0; enb = 1'b0; addrb = '0;

    // Reset state
    cycle(1'b1, 1'b0, 1'b0, 0, 12'h000, 1'b0, 0);
    cycle(1'b1, 1'b0, 1'b0, 0, 12'h000, 1'b0, 0);
    check("reset_doutb", 32'(doutb), 32'h0);

    // First and last pixel
    wr(0, 12'hABC);
    wr(DEPTH - 1, 12'h123);
    rd_expect("first_pixel", 0, 12'hABC);
    rd_expect("last_pixel", DEPTH - 1, 12'h123);

    // Collision: read-first, new data visible on the next read
    wr(100, 12'h0F0);
    cycle(1'b0, 1'b1, 1'b1, 100, 12'h5A5, 1'b1, 100);
    if (LAT > 1) idle(int'(LAT) - 1);
    check("collision_old", 32'(doutb), 32'h0F0);
    rd_expect("collision_new", 100, 12'h5A5);

    // Out-of-range write and read, no wrap onto address 0
    wr(DEPTH, 12'hFFF);
    check("wr_oob_set", 32'(wr_oob), 32'h1);
    rd_expect("oob_read_zero", DEPTH, 12'h000);
    check("rd_oob_set", 32'(rd_oob), 32'h1);
    rd_expect("no_wrap", 0, 12'hABC);

    // Write strobe without enable is ignored; idle read port holds data
    wr(5, 12'h444);
    cycle(1'b0, 1'b0, 1'b1, 5, 12'h777, 1'b0, 0);
    rd_expect("ena_low_blocks", 5, 12'h444);
    idle(int'(LAT) + 1);
    check("hold_data", 32'(doutb), 32'h444);
    check("hold_valid_low", 32'(doutb_valid), 32'h0);

    // Mid-stream reset: outputs and flags clear, writes blocked, memory kept
    wr(7, 12'h321);
    rd(7);
    cycle(1'b1, 1'b1, 1'b1, 7, 12'hEEE, 1'b1, DEPTH + 3);
    cycle(1'b1, 1'b1, 1'b1, DEPTH, 12'hEEE, 1'b1, 7);
    check("rst_flags", 32'({wr_oob, rd_oob, doutb_valid}), 32'h0);
    rd_expect("after_reset", 7, 12'h321);

    // Random traffic concentrated on a few hot addresses and the top boundary
    for (int n = 0; n < 3000; n++) begin
      int aa, ab;
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5: aa = int'($urandom_range(0, 15));
        6, 7:             aa = DEPTH - 8 + int'($urandom_range(0, 15));
        8:                aa = int'($urandom_range(0, 131071));
        default:          aa = int'($urandom_range(0, DEPTH - 1));
      endcase
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5: ab = int'($urandom_range(0, 15));
        6, 7:             ab = DEPTH - 8 + int'($urandom_range(0, 15));
        8:                ab = int'($urandom_range(0, 131071));
        default:          ab = int'($urandom_range(0, DEPTH - 1));
      endcase
      cycle(($urandom_range(0, 99) == 0), 1'($urandom), 1'($urandom), aa,
            12'($urandom), 1'($urandom_range(0, 3) != 0), ab);
    end

    // Full-rate sequential sweep of the whole frame
    for (int a = 0; a < int'(DEPTH); a++) rd(a);
    idle(int'(LAT));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
